// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths and requester index type for the memory port arbiter
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   typedef logic req_idx_t;

   localparam req_idx_t REQ0 = 1'b0;
   localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter onto one external single-port memory
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_rvalid,
   output logic [DATA_W-1:0] req0_rdata,

   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_rvalid,
   output logic [DATA_W-1:0] req1_rdata,

   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   req_idx_t          last_grant;
   req_idx_t          grant_idx;
   logic              grant_any;
   logic              rd_accept;
   logic              rd_pend;
   req_idx_t          rd_idx;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   // Reset masks every grant so nothing can be accepted while rst_n is low.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = REQ0;
      if (rst_n) begin
         if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_idx = ~last_grant;
         end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_idx = REQ0;
         end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_idx = REQ1;
         end
      end
   end

   assign req0_ready = grant_any && (grant_idx == REQ0);
   assign req1_ready = grant_any && (grant_idx == REQ1);

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_any) begin
         if (grant_idx == REQ1) begin
            mem_we    = req1_we;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
         end else begin
            mem_we    = req0_we;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
         end
      end
   end

   assign rd_accept = grant_any && !mem_we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= REQ1;
         rd_pend    <= 1'b0;
         rd_idx     <= REQ0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         if (grant_any) begin
            last_grant <= grant_idx;
         end
         rd_pend <= rd_accept;
         rd_idx  <= grant_idx;
         if (req0_rvalid) begin
            rdata0_q <= mem_rdata;
         end
         if (req1_rvalid) begin
            rdata1_q <= mem_rdata;
         end
      end
   end

   // Gating with rst_n drops a response whose read was accepted just before reset.
   assign req0_rvalid = rst_n && rd_pend && (rd_idx == REQ0);
   assign req1_rvalid = rst_n && rd_pend && (rd_idx == REQ1);

   // Memory read data is registered externally, so it passes straight through in the response cycle.
   assign req0_rdata = req0_rvalid ? mem_rdata : rdata0_q;
   assign req1_rdata = req1_rvalid ? mem_rdata : rdata1_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the memory address width (16 words).
REQ-002 Parameter DATA_W, default 8, SHALL set the memory data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 reqN_valid  input  1  (N=0,1) SHALL indicate requester N presents a transaction.
REQ-006 reqN_we  input  1  SHALL select write (1) or read (0) for requester N.
REQ-007 reqN_addr  input  ADDR_W  SHALL give requester N's word address.
REQ-008 reqN_wdata  input  DATA_W  SHALL give requester N's write data.
REQ-009 reqN_ready  output  1  SHALL indicate requester N's transaction is accepted this cycle.
REQ-010 reqN_rvalid  output  1  SHALL flag a read response for requester N.
REQ-011 reqN_rdata  output  DATA_W  SHALL carry requester N's read data, qualified by reqN_rvalid.
REQ-012 mem_we  output  1  SHALL be the write enable to the shared single-port memory.
REQ-013 mem_addr  output  ADDR_W  SHALL be the shared memory address.
REQ-014 mem_wdata  output  DATA_W  SHALL be the shared memory write data.
REQ-015 mem_rdata  input  DATA_W  SHALL be the memory's registered read data, valid one cycle after the address is presented, read-before-write.

Function
REQ-016 At most one of req0_ready/req1_ready SHALL be high in any cycle; a transaction is accepted when valid && ready.
REQ-017 ready SHALL be combinational from valid and arbitration state; ready SHALL never be high while the matching valid is low.
REQ-018 Single requester valid: that requester SHALL be granted in the same cycle.
REQ-019 Both valid: grant SHALL go to the requester not recorded in last_grant (round-robin); last_grant SHALL update to the granted index on every acceptance.
REQ-020 No valid: no grant; last_grant SHALL hold; mem_we=0; mem_addr, mem_wdata SHALL be 0.
REQ-021 On acceptance, mem_addr/mem_wdata SHALL equal the granted requester's addr/wdata and mem_we SHALL equal its we, in the same cycle.
REQ-022 An accepted read SHALL produce reqN_rvalid=1 for exactly one cycle, exactly one cycle after acceptance, with reqN_rdata = mem_rdata in that cycle.
REQ-023 Accepted writes SHALL produce no rvalid.
REQ-024 reqN_rdata SHALL hold its last value while reqN_rvalid=0.
REQ-025 Back-to-back reads (one per cycle, any requester mix) SHALL be fully pipelined: throughput one transaction per cycle, no bubbles.
REQ-026 A read to address A accepted the cycle after a write to A SHALL return the new data; a read and write cannot share a cycle (single port).
REQ-027 A requester not granted SHALL keep valid and payload stable until ready; the arbiter relies on, but does not check, this.

Reset
REQ-028 While rst_n=0 at posedge clk: last_grant SHALL become 1 (requester 0 wins first conflict); both rvalid SHALL become 0; both rdata SHALL become 0; the read-pending pipeline register SHALL clear.
REQ-029 While rst_n=0, both ready and mem_we SHALL be 0 combinationally, so no transaction is accepted.
REQ-030 A read accepted in the cycle before reset asserts SHALL NOT produce rvalid.

Structure
REQ-031 ADDR_W/DATA_W defaults and a requester-index typedef (1 bit) SHALL live in shared package mem_arb_pkg.
REQ-032 No sub-module SHALL be instantiated; the memory is external; arbitration and response tracking SHALL be flat in this module.

Verification
REQ-033 Reset, then req0 write addr 3 data 0xA5, next cycle req0 read addr 3 -> req0_rvalid=1 one cycle later with req0_rdata=0xA5; req1_rvalid stays 0.
REQ-034 Both valid continuously after reset, reads of addr 0 / addr 1 -> grants alternate 0,1,0,1; each rvalid follows its grant by one cycle.
REQ-035 req1 alone valid for 3 cycles -> req1_ready=1 each cycle, last_grant=1; then both valid -> req0 granted.
REQ-036 Write addr 15 data 0x3C then read addr 15 on consecutive cycles, two requesters -> reader receives 0x3C (wrap-top address correct).
REQ-037 Read accepted, rst_n=0 next cycle -> no rvalid; ready=0 and mem_we=0 throughout reset; first post-reset conflict grants req0.
REQ-038 Random traffic against a 16x8 scoreboard model -> every rvalid data matches, no double grant, no lost transaction.
